det_logger: RTL and testbench
=============================

DET_LOGGER -- requirements
Module: det_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the event FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter TS_W, default 16, giving the timestamp width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port detected, input, 1 bit, a single-cycle match pulse from the upstream sequence detector.
REQ-006 SHALL have port clear, input, 1 bit, a synchronous flush of FIFO, overflow and counters.
REQ-007 SHALL have port ev_valid, output, 1 bit, high when the FIFO head entry is presented.
REQ-008 SHALL have port ev_ready, input, 1 bit, the consumer accept signal.
REQ-009 SHALL have port ev_ts, output, TS_W bits, the timestamp of the head entry.
REQ-010 SHALL have port overflow, output, 1 bit, a sticky flag set when an event is lost.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-012 SHALL keep a free-running TS_W-bit timestamp counter, incremented every cycle and wrapping from all-ones to 0.
REQ-013 SHALL push the timestamp value of the cycle in which detected=1 (before its increment); latency to ev_valid SHALL be 1 cycle from an empty FIFO.
REQ-014 SHALL complete a pop on a cycle where ev_valid=1 and ev_ready=1; ev_ts SHALL then show the next entry on the following cycle.
REQ-015 SHALL hold ev_valid and ev_ts stable while ev_valid=1 and ev_ready=0.
REQ-016 SHALL ignore ev_ready when the FIFO is empty; ev_valid SHALL stay 0.
REQ-017 SHALL, on a push into a full FIFO with no pop that cycle, drop the new event, keep the contents, and set overflow to 1.
REQ-018 SHALL, on a push into a full FIFO with a pop in the same cycle, accept both; level stays DEPTH and overflow is unchanged.
REQ-019 SHALL, on a push and pop in the same cycle at level 1, leave the new entry at the head with ev_valid remaining 1.
REQ-020 SHALL give clear priority over push and pop in the same cycle: level=0, ev_valid=0, overflow=0, and the timestamp counter = 0 on the next cycle.
REQ-021 SHALL NOT reset the timestamp counter on a pop or on overflow.
REQ-022 SHALL use 2-state read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force ev_valid=0, ev_ts=0, overflow=0, level=0, both pointers=0, and the timestamp counter=0.
REQ-024 SHALL, when reset is asserted mid-operation, discard all pending entries; no event captured before the rst_n deassertion edge SHALL be output.
REQ-025 SHALL ignore a detected pulse in the first cycle after rst_n deasserts only if it coincides with the deassertion edge.

Configuration
REQ-026 SHALL, when macro DET_LOGGER_DROP_CNT_EN is defined, add output drop_cnt, 8 bits: incremented per dropped event, saturating at 255, zeroed by reset and clear.
REQ-027 SHALL, without DET_LOGGER_DROP_CNT_EN, have no drop_cnt port and no associated logic; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL take from shared package seq_det_pkg the state_t enum (S0..S3) and a ts_t typedef of TS_W default width.
REQ-029 SHALL instantiate one sub-module det_fifo (storage, pointers, level, full/empty); timestamping, overflow and drop counting SHALL stay in det_logger.

Verification
REQ-030 Bench SHALL check: reset, then detected at timestamp 5 -> ev_valid=1 next cycle, ev_ts=5, level=1.
REQ-031 Bench SHALL check: 5 pulses with ev_ready=0, DEPTH=4 -> level=4, overflow=1, drop_cnt=1 (if enabled), and entries read back in order.
REQ-032 Bench SHALL check: full FIFO, detected and ev_ready on the same cycle -> level stays 4, overflow stays 0, and the new timestamp appears last.
REQ-033 Bench SHALL check: timestamp at 0xFFFF, pulses on consecutive cycles -> ev_ts sequence 0xFFFF, 0x0000.
REQ-034 Bench SHALL check: clear asserted with detected=1 and 3 entries queued -> next cycle level=0, ev_valid=0, overflow=0, and no entry logged.
REQ-035 Bench SHALL check: rst_n pulsed low mid-stream with 2 entries queued -> ev_valid drops immediately (asynchronously) and stays 0 until a new pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg -- types shared by the sequence detector and its event logger.
//   state_t : detector FSM state encoding (S0..S3)
//   ts_t    : timestamp type at the default timestamp width
//   lvl_w() : width of a FIFO occupancy count for a given depth
package seq_det_pkg;

    localparam int TS_W_DEF = 16;

    typedef logic [TS_W_DEF-1:0] ts_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/det_logger_if.sv
// det_logger_if -- event output handshake of det_logger.
//   ev_valid : head entry presented (producer -> consumer)
//   ev_ts    : timestamp of head entry (producer -> consumer)
//   ev_ready : consumer accepts head entry (consumer -> producer)
// Modports: master = logger side, slave = consumer side.
interface det_logger_if #(
    parameter int TS_W = 16
);
    logic            ev_valid;
    logic            ev_ready;
    logic [TS_W-1:0] ev_ts;

    modport master (output ev_valid, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_ts, output ev_ready);
endinterface

// File: rtl/det_fifo.sv
// det_fifo -- circular event store for det_logger.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous flush (wins over push/pop)
//   push, din  : write request and data (taken if not full, or if popping)
//   pop        : read request (taken if not empty)
//   dout       : head entry
//   level      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module det_fifo
    import seq_det_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          wr_en, rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A push into a full FIFO is only legal when the head leaves the same
    // cycle; the write then lands in the slot being vacated.
    assign rd_en = pop  & ~empty & ~clr;
    assign wr_en = push & (~full | rd_en) & ~clr;

    assign dout = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

endmodule

// File: rtl/det_logger.sv
// det_logger -- timestamps detector match pulses into a small FIFO.
//   clk, rst_n : clock, async active-low reset
//   detected   : one-cycle match pulse; logs the current timestamp
//   clear      : synchronous flush of FIFO, overflow, counters, timestamp
//   ev         : event handshake (ev_valid / ev_ts out, ev_ready in)
//   overflow   : sticky, set when an event is dropped on a full FIFO
//   level      : FIFO occupancy
//   drop_cnt   : saturating dropped-event count (DET_LOGGER_DROP_CNT_EN only)
// Optional feature macro: DET_LOGGER_DROP_CNT_EN.
module det_logger
    import seq_det_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   detected,
    input  logic                   clear,
    det_logger_if.master           ev,
    output logic                   overflow,
`ifdef DET_LOGGER_DROP_CNT_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic [$clog2(DEPTH):0] level
);

    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] head;
    logic            full, empty;
    logic            pop, drop, push;

    assign pop  = ev.ev_valid & ev.ev_ready;
    // A full FIFO still takes the new event if the head leaves this cycle.
    assign drop = detected & full & ~pop & ~clear;
    assign push = detected & ~drop;

    det_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .push  (push),
        .pop   (pop),
        .din   (ts_cnt),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Gate the head so ev_ts reads 0 whenever nothing is presented,
    // including during reset when storage is stale.
    assign ev.ev_valid = ~empty;
    assign ev.ev_ts    = empty ? '0 : head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            ts_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef DET_LOGGER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (clear) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_det_logger.sv
// tb_det_logger -- directed self-checking bench for det_logger (DEPTH=4, TS_W=16).
// Inputs change just after the falling edge; outputs are sampled there too,
// so every check sees the state after the preceding rising edge.
module tb_det_logger;
    import seq_det_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       detected;
    logic       clear;
    logic       overflow;
    logic [2:0] level;
`ifdef DET_LOGGER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    det_logger_if #(.TS_W(16)) ev_if ();

    det_logger #(.DEPTH(4), .TS_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .detected (detected),
        .clear    (clear),
        .ev       (ev_if),
        .overflow (overflow),
`ifdef DET_LOGGER_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .level    (level)
    );

    always #5 clk = ~clk;

    // One rising edge, returning at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clear then leaves the timestamp counter at 0.
    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; detected = 1'b0; clear = 1'b0; ev_if.ev_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", ev_if.ev_valid); end
        n_chk++; if (ev_if.ev_ts !== 16'h0) begin n_fail++; $display("FAIL reset_ts got %h want 0000", ev_if.ev_ts); end
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
`ifdef DET_LOGGER_DROP_CNT_EN
        n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
`endif
        rst_n = 1'b1;   // released mid-cycle, timestamp = 0
    endtask

    task automatic test_first_event();
        repeat (5) tick();                       // timestamp now 5
        detected = 1'b1; tick(); detected = 1'b0;
        n_chk++; if (ev_if.ev_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %0b want 1", ev_if.ev_valid); end
        n_chk++; if (ev_if.ev_ts !== 16'd5) begin n_fail++; $display("FAIL first_ts got %0d want 5", ev_if.ev_ts); end
        n_chk++; if (level !== 3'd1) begin n_fail++; $display("FAIL first_level got %0d want 1", level); end
        ev_if.ev_ready = 1'b1; tick();
        n_chk++; if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid got %0b want 0", ev_if.ev_valid); end
        tick();                                  // ready while empty: ignored
        n_chk++; if (ev_if.ev_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL empty_ready got v=%0b l=%0d want v=0 l=0", ev_if.ev_valid, level); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ts;
        do_clear();
        detected = 1'b1; repeat (5) tick(); detected = 1'b0;   // 0..3 kept, 4 dropped
        n_chk++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", level); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
`ifdef DET_LOGGER_DROP_CNT_EN
        n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
`endif
        tick();                                  // stall: head must hold
        n_chk++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_ts !== 16'd0) begin n_fail++; $display("FAIL stall_hold got v=%0b ts=%0d want v=1 ts=0", ev_if.ev_valid, ev_if.ev_ts); end
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ts = 16'(i);
            n_chk++; if (ev_if.ev_ts !== exp_ts) begin n_fail++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, ev_if.ev_ts, exp_ts); end
            tick();
        end
        ev_if.ev_ready = 1'b0;
        n_chk++; if (ev_if.ev_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drain got v=%0b ovf=%0b want v=0 ovf=1", ev_if.ev_valid, overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_ts;
        do_clear();
        detected = 1'b1; repeat (4) tick();      // 0,1,2,3; timestamp now 4
        ev_if.ev_ready = 1'b1; tick();           // pop 0, push 4
        detected = 1'b0;
        n_chk++; if (level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp got l=%0d ovf=%0b want l=4 ovf=0", level, overflow); end
        for (int i = 1; i <= 4; i++) begin
            exp_ts = 16'(i);
            n_chk++; if (ev_if.ev_ts !== exp_ts) begin n_fail++; $display("FAIL fullpp_order[%0d] got %0d want %0d", i, ev_if.ev_ts, exp_ts); end
            tick();
        end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        detected = 1'b1; tick();                 // entry 0
        ev_if.ev_ready = 1'b1; tick();           // pop 0, push 1 at level 1
        detected = 1'b0;
        n_chk++; if (ev_if.ev_valid !== 1'b1 || level !== 3'd1 || ev_if.ev_ts !== 16'd1) begin n_fail++; $display("FAIL lvl1pp got v=%0b l=%0d ts=%0d want v=1 l=1 ts=1", ev_if.ev_valid, level, ev_if.ev_ts); end
        tick();
        ev_if.ev_ready = 1'b0;
        n_chk++; if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL lvl1pp_drain got %0b want 0", ev_if.ev_valid); end
    endtask

    task automatic test_wrap();
        do_clear();
        repeat (65535) tick();                   // timestamp now FFFF
        detected = 1'b1; repeat (2) tick(); detected = 1'b0;
        n_chk++; if (ev_if.ev_ts !== 16'hFFFF || level !== 3'd2) begin n_fail++; $display("FAIL wrap_first got ts=%h l=%0d want ts=ffff l=2", ev_if.ev_ts, level); end
        ev_if.ev_ready = 1'b1; tick();
        n_chk++; if (ev_if.ev_ts !== 16'h0000 || ev_if.ev_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_second got ts=%h v=%0b want ts=0000 v=1", ev_if.ev_ts, ev_if.ev_valid); end
        tick(); ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        detected = 1'b1; repeat (5) tick(); detected = 1'b0;   // full + overflow
        ev_if.ev_ready = 1'b1; tick(); ev_if.ev_ready = 1'b0;  // 3 queued
        n_chk++; if (level !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL clr_setup got l=%0d ovf=%0b want l=3 ovf=1", level, overflow); end
        clear = 1'b1; detected = 1'b1; ev_if.ev_ready = 1'b1; tick();
        clear = 1'b0; detected = 1'b0; ev_if.ev_ready = 1'b0;  // timestamp now 0
        n_chk++; if (level !== 3'd0 || ev_if.ev_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr got l=%0d v=%0b ovf=%0b want 0 0 0", level, ev_if.ev_valid, overflow); end
`ifdef DET_LOGGER_DROP_CNT_EN
        n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
`endif
        tick();                                  // timestamp now 1
        n_chk++; if (level !== 3'd0) begin n_fail++; $display("FAIL clr_nolog got l=%0d want 0", level); end
        detected = 1'b1; tick(); detected = 1'b0;
        n_chk++; if (ev_if.ev_ts !== 16'd1) begin n_fail++; $display("FAIL clr_ts got %0d want 1", ev_if.ev_ts); end
        ev_if.ev_ready = 1'b1; tick(); ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_clear();
        detected = 1'b1; repeat (2) tick(); detected = 1'b0;
        n_chk++; if (level !== 3'd2) begin n_fail++; $display("FAIL rst_setup got l=%0d want 2", level); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (ev_if.ev_valid !== 1'b0 || level !== 3'd0 || ev_if.ev_ts !== 16'h0) begin n_fail++; $display("FAIL rst_async got v=%0b l=%0d ts=%0d want 0 0 0", ev_if.ev_valid, level, ev_if.ev_ts); end
        @(negedge clk);
        rst_n = 1'b1;                            // timestamp 0
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stay[%0d] got %0b want 0", i, ev_if.ev_valid); end
        end
        detected = 1'b1; tick(); detected = 1'b0;
        n_chk++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_ts !== 16'd3) begin n_fail++; $display("FAIL rst_new got v=%0b ts=%0d want v=1 ts=3", ev_if.ev_valid, ev_if.ev_ts); end
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
